// File: rtl/lsu.sv
// Load/store unit of the memory stage.
// Turns the decoded memory op held in the execute-to-memory register into a
// single request/grant/response bus transaction, stalls the pipeline until
// that transaction completes, and aligns and extends load data for writeback.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of force-aligning them.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_we_i,
  input  logic [31:0] rd_mem_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        rd_we_o,
  output logic [31:0] rd_wdata_o,
  output logic [4:0]  rd_addr_o,
  output logic        stall_req_o,
  output logic        misalign_o,
  output logic [31:0] bad_addr_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  state_e      state_q;
  state_e      state_d;

  logic        size_half_s;
  logic        size_word_s;
  logic [1:0]  off_s;
  logic        trap_s;
  logic        mem_op_s;
  logic        req_s;
  logic        stall_s;
  logic        done_s;
  logic [31:0] load_data_s;

  // Byte-lane enables for an access of the given size at the given offset.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across all lanes so any enabled lane carries it.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      2'd0:    wd = {4{data[7:0]}};
      2'd1:    wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

  // Shift the addressed lanes down to bit 0, then sign- or zero-extend.
  // Words always reach here with offset 0, so the shift leaves them unchanged.
  function automatic logic [31:0] load_ext(input logic [1:0] size, input logic uns,
                                           input logic [1:0] off, input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] ext;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'd0:    ext = {{24{~uns & sh[7]}}, sh[7:0]};
      2'd1:    ext = {{16{~uns & sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
    return ext;
  endfunction

  assign size_half_s = (mem_size_i == 2'd1);
  assign size_word_s = mem_size_i[1];

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned_s;

  // Misaligned ops are trapped; aligned ops use their natural offset.
  always_comb begin
    misaligned_s = (size_half_s & mem_addr_i[0]) | (size_word_s & (mem_addr_i[1:0] != 2'b00));
    trap_s       = misaligned_s & (mem_re_i | mem_we_i);
    off_s        = mem_addr_i[1:0];
  end
`else
  // Misaligned ops are force-aligned: halves drop addr[0], words use offset 0.
  always_comb begin
    trap_s = 1'b0;
    if (size_word_s) begin
      off_s = 2'b00;
    end else if (size_half_s) begin
      off_s = {mem_addr_i[1], 1'b0};
    end else begin
      off_s = mem_addr_i[1:0];
    end
  end
`endif

  assign mem_op_s    = (mem_re_i | mem_we_i) & ~trap_s;
  assign load_data_s = load_ext(mem_size_i, mem_unsigned_i, off_s, bus_rdata_i);

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus request/stall/done decode for the single outstanding access.
  always_comb begin
    state_d = state_q;
    req_s   = 1'b0;
    stall_s = 1'b0;
    done_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op_s) begin
          req_s   = 1'b1;
          stall_s = 1'b1;
          state_d = bus_gnt_i ? WAIT_RSP : WAIT_GNT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_GNT: begin
        req_s   = 1'b1;
        stall_s = 1'b1;
        if (bus_gnt_i) begin
          state_d = WAIT_RSP;
        end else begin
          state_d = WAIT_GNT;
        end
      end
      WAIT_RSP: begin
        if (bus_rvalid_i) begin
          done_s  = 1'b1;
          state_d = IDLE;
        end else begin
          stall_s = 1'b1;
          state_d = WAIT_RSP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus request fields come straight from the held pipeline register.
  always_comb begin
    bus_req_o   = rst_n & req_s;
    bus_we_o    = mem_we_i;
    bus_addr_o  = {mem_addr_i[31:2], 2'b00};
    bus_be_o    = lane_be(mem_size_i, off_s);
    bus_wdata_o = lane_wdata(mem_size_i, rd_mem_data_i);
    stall_req_o = rst_n & stall_s;
  end

  // Writeback triple and exception outputs.
  always_comb begin
    rd_addr_o  = rd_addr_i;
    rd_we_o    = 1'b0;
    rd_wdata_o = 32'h0000_0000;
    misalign_o = rst_n & trap_s;
    bad_addr_o = 32'h0000_0000;
    if (trap_s) begin
      bad_addr_o = mem_addr_i;
    end else if (mem_re_i) begin
      rd_we_o    = rst_n & rd_we_i & done_s;
      rd_wdata_o = done_s ? load_data_s : 32'h0000_0000;
    end else if (mem_we_i) begin
      rd_we_o    = 1'b0;
    end else begin
      rd_we_o    = rst_n & rd_we_i;
      rd_wdata_o = rd_mem_data_i;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized scoreboard bench for the load/store unit.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_we_i;
  logic [31:0] rd_mem_data_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] mem_addr_i;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        rd_we_o;
  logic [31:0] rd_wdata_o;
  logic [4:0]  rd_addr_o;
  logic        stall_req_o;
  logic        misalign_o;
  logic [31:0] bad_addr_o;

  lsu dut (
    .clk(clk), .rst_n(rst_n),
    .rd_we_i(rd_we_i), .rd_mem_data_i(rd_mem_data_i), .rd_addr_i(rd_addr_i),
    .mem_addr_i(mem_addr_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .rd_we_o(rd_we_o), .rd_wdata_o(rd_wdata_o), .rd_addr_o(rd_addr_o),
    .stall_req_o(stall_req_o), .misalign_o(misalign_o), .bad_addr_o(bad_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          req;
    bit          store;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          rd_we;
    logic [31:0] rd_wdata;
    logic [4:0]  rd_addr;
    bit          misalign;
    logic [31:0] bad_addr;
    int          stall_cycles;
    int          req_cycles;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   stall_cnt = 0;
  int   req_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference behaviour computed byte by byte from the access rules.
  function automatic exp_t model(input bit re, input bit we, input logic [1:0] size,
                                 input bit uns, input logic [31:0] addr,
                                 input logic [31:0] data, input bit rdwe,
                                 input logic [4:0] rda, input int gd, input int rdl,
                                 input logic [31:0] rdata);
    exp_t e;
    int off;
    int n;
    bit mis;
    longint unsigned v;
    longint unsigned word;
    longint unsigned bt;
    off = int'(addr % 32'd4);
    n   = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
    mis = (n == 2 && (off % 2) == 1) || (n == 4 && off != 0);
    e.req = 0; e.store = 0; e.we = we; e.addr = addr - 32'(off); e.be = 4'h0;
    e.wdata = 32'h0; e.rd_we = 0; e.rd_wdata = 32'h0; e.rd_addr = rda;
    e.misalign = 0; e.bad_addr = 32'h0; e.stall_cycles = 0; e.req_cycles = 0;
    if (!re && !we) begin
      e.rd_we = rdwe;
      e.rd_wdata = data;
      return e;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      e.misalign = 1;
      e.bad_addr = addr;
      return e;
    end
`else
    mis = mis;
`endif
    if (n == 2) off = off - (off % 2);
    if (n == 4) off = 0;
    e.req = 1;
    e.req_cycles = gd + 1;
    e.stall_cycles = gd + 1 + rdl;
    for (int i = 0; i < n; i++) e.be = e.be + 4'(1 << (off + i));
    if (n == 1)      e.wdata = (data % 32'd256) * 32'h0101_0101;
    else if (n == 2) e.wdata = (data % 32'd65536) * 32'h0001_0001;
    else             e.wdata = data;
    if (we) begin
      e.store = 1;
      return e;
    end
    word = 64'(rdata);
    v = 64'd0;
    for (int i = 0; i < n; i++) begin
      bt = (word / (64'd1 << (8 * (off + i)))) % 64'd256;
      v  = v + bt * (64'd1 << (8 * i));
    end
    if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
    e.rd_we = rdwe;
    e.rd_wdata = v[31:0];
    return e;
  endfunction

  // Presents one op and plays the bus side; called just after a rising edge.
  task automatic run_op(input bit re, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] data, input bit rdwe,
                        input logic [4:0] rda, input int gd, input int rdl,
                        input logic [31:0] rdata);
    exp_t e;
    e = model(re, we, size, uns, addr, data, rdwe, rda, gd, rdl, rdata);
    q.push_back(e);
    mem_re_i = re; mem_we_i = we; mem_size_i = size; mem_unsigned_i = uns;
    mem_addr_i = addr; rd_mem_data_i = data; rd_we_i = rdwe; rd_addr_i = rda;
    bus_rdata_i = $urandom;
    if (!e.req) begin
      bus_gnt_i = 1'b0;
      bus_rvalid_i = 1'($urandom % 2);
      @(posedge clk); #1;
      bus_rvalid_i = 1'b0;
    end else begin
      bus_rvalid_i = 1'b0;
      bus_gnt_i = (gd == 0);
      for (int k = 0; k < gd; k++) begin
        @(posedge clk); #1;
        bus_gnt_i = (k == gd - 1);
      end
      @(posedge clk); #1;
      bus_gnt_i = 1'b0;
      bus_rdata_i = rdata;
      bus_rvalid_i = (rdl == 0);
      for (int k = 0; k < rdl; k++) begin
        @(posedge clk); #1;
        bus_rvalid_i = (k == rdl - 1);
      end
      @(posedge clk); #1;
      bus_rvalid_i = 1'b0;
    end
  endtask

  // Monitor: checks bus fields while requesting and the writeback when an op retires.
  always @(negedge clk) begin
    if (mon_en && rst_n && q.size() > 0) begin
      if (bus_req_o) begin
        req_cnt++;
        if (q[0].req) begin
          chk("bus_addr", bus_addr_o, q[0].addr);
          chk("bus_be", 32'(bus_be_o), 32'(q[0].be));
          chk("bus_we", 32'(bus_we_o), 32'(q[0].we));
          if (q[0].store) chk("bus_wdata", bus_wdata_o, q[0].wdata);
        end
      end
      if (stall_req_o) begin
        stall_cnt++;
        chk("rd_we_pending", 32'(rd_we_o), 32'd0);
      end else begin
        chk("rd_we", 32'(rd_we_o), 32'(q[0].rd_we));
        if (!q[0].store) chk("rd_wdata", rd_wdata_o, q[0].rd_wdata);
        chk("rd_addr", 32'(rd_addr_o), 32'(q[0].rd_addr));
        chk("misalign", 32'(misalign_o), 32'(q[0].misalign));
        chk("bad_addr", bad_addr_o, q[0].bad_addr);
        chk("stall_cycles", 32'(stall_cnt), 32'(q[0].stall_cycles));
        chk("req_cycles", 32'(req_cnt), 32'(q[0].req_cycles));
        void'(q.pop_front());
        stall_cnt = 0;
        req_cnt = 0;
      end
    end
  end

  initial begin
    int kind;
    rst_n = 1'b0;
    rd_we_i = 1'b1; rd_mem_data_i = 32'h0; rd_addr_i = 5'd0;
    mem_addr_i = 32'h0000_4001; mem_re_i = 1'b1; mem_we_i = 1'b0;
    mem_size_i = 2'd2; mem_unsigned_i = 1'b0;
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0;

    // Outputs forced low while reset is held, even with an op present.
    @(posedge clk); @(negedge clk);
    chk("rst_bus_req", 32'(bus_req_o), 32'd0);
    chk("rst_stall", 32'(stall_req_o), 32'd0);
    chk("rst_rd_we", 32'(rd_we_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    mon_en = 1'b1;

    // Directed cases from the plan.
    run_op(0, 0, 2'd2, 0, 32'h0000_0000, 32'h0000_1234, 1, 5'd5, 0, 0, 32'h0);
    run_op(1, 0, 2'd0, 0, 32'h0000_1003, 32'h0, 1, 5'd7, 0, 0, 32'h80AA_BBCC);
    run_op(1, 0, 2'd1, 1, 32'h0000_2002, 32'h0, 1, 5'd8, 2, 0, 32'h9ABC_0000);
    run_op(0, 1, 2'd1, 0, 32'h0000_3002, 32'h0000_BEEF, 1, 5'd9, 0, 1, 32'h0);
    run_op(1, 0, 2'd2, 0, 32'h0000_4001, 32'h0, 1, 5'd10, 1, 1, 32'h1122_3344);

    // Randomized ops.
    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom % 4);
      run_op(kind == 1 || kind == 2, kind == 3, 2'($urandom % 4), 1'($urandom % 2),
             $urandom, $urandom, 1'($urandom % 2), 5'($urandom % 32),
             int'($urandom % 3), int'($urandom % 3), $urandom);
    end

    mem_re_i = 1'b0; mem_we_i = 1'b0; rd_we_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    mon_en = 1'b0;
    q.delete();

    // Reset during WAIT_RSP abandons the access; a late response is ignored.
    mem_re_i = 1'b1; mem_size_i = 2'd2; mem_addr_i = 32'h0000_5000; rd_we_i = 1'b1;
    rd_addr_i = 5'd3; bus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall", 32'(stall_req_o), 32'd0);
    chk("rst_mid_req", 32'(bus_req_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_re_i = 1'b0; mem_we_i = 1'b0; rd_we_i = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", 32'(stall_req_o), 32'd0);
    @(posedge clk); #1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_rvalid_rd_we", 32'(rd_we_o), 32'd0);
    chk("late_rvalid_stall", 32'(stall_req_o), 32'd0);
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
